// File: rtl/svm_coef_loader.sv
// Streams SVM coefficients from a host into packed RAM words, then loads the bias.
// One RAM word holds N_COEF coefficients; N_ADDR words plus one bias word form a full set.
module svm_coef_loader #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned N_COEF = 105,
  parameter int unsigned N_ADDR = 36,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [COEF_W-1:0]        s_data,
  output logic [ADDR_W-1:0]        addr_a,
  output logic                     write_en,
  output logic [COEF_W*N_COEF-1:0] o_data,
  output logic [COEF_W-1:0]        bias,
  output logic                     b_load,
  input  logic                     fifo_ready,
  output logic                     hog_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  typedef enum logic [2:0] {StIdle, StCollect, StWrite, StBias, StBload, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         coef_cnt_q, coef_cnt_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [COEF_W*N_COEF-1:0] word_q, word_d;
  logic [COEF_W-1:0]        bias_q, bias_d;
  logic                     restart, last_coef, last_addr;

  // start is only honoured when no load is in flight
  assign restart   = start && (state_q == StIdle || state_q == StDone);
  assign last_coef = (coef_cnt_q == CNT_W'(N_COEF - 1));
  assign last_addr = (addr_q == ADDR_W'(N_ADDR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StCollect;
      StCollect:      if (s_valid && last_coef) state_d = StWrite;
      StWrite:        state_d = last_addr ? StBias : StCollect;
      StBias:         if (s_valid) state_d = StBload;
      StBload:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == StCollect) || (state_q == StBias);
    write_en  = (state_q == StWrite);
    b_load    = (state_q == StBload);
    busy      = (state_q == StCollect) || (state_q == StWrite) ||
                (state_q == StBias)    || (state_q == StBload);
    done      = (state_q == StDone);
    hog_ready = fifo_ready && done;
    addr_a    = addr_q;
    o_data    = word_q;
    bias      = bias_q;
  end

  always_comb begin
    coef_cnt_d = coef_cnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
    bias_d     = bias_q;
    if (restart) begin
      coef_cnt_d = '0;
      addr_d     = '0;
    end
    if (state_q == StCollect && s_valid) begin
      word_d[coef_cnt_q*COEF_W +: COEF_W] = s_data;
      coef_cnt_d = last_coef ? '0 : coef_cnt_q + CNT_W'(1);
    end
    if (state_q == StWrite) begin
      coef_cnt_d = '0;
      if (!last_addr) addr_d = addr_q + ADDR_W'(1);
    end
    if (state_q == StBias && s_valid) bias_d = s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_cnt_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      bias_q     <= '0;
    end else begin
      coef_cnt_q <= coef_cnt_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      bias_q     <= bias_d;
    end
  end

endmodule

// File: tb/tb_svm_coef_loader.sv
// Directed bench for svm_coef_loader: full loads, stream gaps, ignored start, mid-load reset.
module tb_svm_coef_loader;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned N_COEF = 105;
  localparam int unsigned N_ADDR = 36;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned N_WORDS = N_COEF * N_ADDR;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [COEF_W-1:0]        s_data = '0;
  logic [ADDR_W-1:0]        addr_a;
  logic                     write_en;
  logic [COEF_W*N_COEF-1:0] o_data;
  logic [COEF_W-1:0]        bias;
  logic                     b_load;
  logic                     fifo_ready = 1'b1;
  logic                     hog_ready;
  logic                     busy;
  logic                     done;

  svm_coef_loader #(
    .COEF_W(COEF_W),
    .N_COEF(N_COEF),
    .N_ADDR(N_ADDR),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .addr_a    (addr_a),
    .write_en  (write_en),
    .o_data    (o_data),
    .bias      (bias),
    .b_load    (b_load),
    .fifo_ready(fifo_ready),
    .hog_ready (hog_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int cyc, wr_cnt, bl_cnt, done_rises, first_wr, last_wr, bl_cyc, done_cyc, idx;
  bit pend, gaps, prev_done, aborted;
  logic [COEF_W-1:0] bias_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe the cycle's outputs at negedge, then drive the next stream word.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (write_en === 1'b1) begin
      check("wr_addr", 32'(addr_a), 32'(wr_cnt));
      for (int k = 0; k < N_COEF; k++) begin
        check("wr_slice", 32'(o_data[k*COEF_W +: COEF_W]), 32'((wr_cnt * N_COEF + k) % 4096));
      end
      if (wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
    if (b_load === 1'b1) begin
      check("bload_bias", 32'(bias), 32'(bias_val));
      bl_cnt++;
      bl_cyc = cyc;
    end
    if (done === 1'b1 && !prev_done) begin
      done_rises++;
      done_cyc = cyc;
    end
    prev_done = (done === 1'b1);
    if (pend) idx++;
    s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    s_data  = (idx == N_WORDS) ? bias_val : COEF_W'(idx % 4096);
    pend    = s_valid && (s_ready === 1'b1);
    start   = 1'b0;
  endtask

  // Called at a negedge; start is sampled at the following edge (edge 0).
  task automatic run_load(input bit g, input bit glitch, input bit abort, input logic [11:0] bv);
    bit glitch_done;
    gaps = g;
    bias_val = bv;
    wr_cnt = 0; bl_cnt = 0; done_rises = 0; idx = 0; pend = 1'b0;
    first_wr = -1; last_wr = -1; bl_cyc = -1; done_cyc = -1;
    glitch_done = 1'b0;
    aborted = 1'b0;
    start = 1'b1;
    cyc = -1;
    for (int n = 0; n < 20000 && done_rises == 0 && !aborted; n++) begin
      step();
      if (n == 0) begin
        check("first_busy", 32'(busy), 32'd1);
        check("first_done", 32'(done), 32'd0);
        check("first_hog", 32'(hog_ready), 32'd0);
      end
      if (glitch && !glitch_done && wr_cnt == 10 && s_ready === 1'b1) begin
        start = 1'b1;
        glitch_done = 1'b1;
      end
      if (abort && wr_cnt == 21) begin
        rst = 1'b0;
        #1;
        check("abort_sready", 32'(s_ready), 32'd0);
        check("abort_wen", 32'(write_en), 32'd0);
        check("abort_bload", 32'(b_load), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hog", 32'(hog_ready), 32'd0);
        check("abort_addr", 32'(addr_a), 32'd0);
        check("abort_bias", 32'(bias), 32'd0);
        aborted = 1'b1;
      end
    end
    if (!aborted) check("load_finished", 32'(done_rises), 32'd1);
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_first_wr"}, 32'(first_wr), 32'd105);
    check({tag, "_last_wr"}, 32'(last_wr), 32'd3815);
    check({tag, "_bload_cyc"}, 32'(bl_cyc), 32'd3817);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'd3818);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd36);
    check({tag, "_bl_cnt"}, 32'(bl_cnt), 32'd1);
  endtask

  initial begin
    cyc = 0; gaps = 1'b0; pend = 1'b0; prev_done = 1'b0; bias_val = '0; idx = 0;
    wr_cnt = 0; bl_cnt = 0; done_rises = 0;
    repeat (3) @(negedge clk);
    check("rst_sready", 32'(s_ready), 32'd0);
    check("rst_wen", 32'(write_en), 32'd0);
    check("rst_bload", 32'(b_load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hog", 32'(hog_ready), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_bias", 32'(bias), 32'd0);

    // Reset release alone must not start a load
    rst = 1'b1;
    repeat (6) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_wr", 32'(wr_cnt), 32'd0);

    // Full back-to-back load
    run_load(1'b0, 1'b0, 1'b0, 12'd3780);
    check_timing("full");
    step();
    check("full_bias_held", 32'(bias), 32'd3780);
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_sready", 32'(s_ready), 32'd0);
    check("hog_follow_1", 32'(hog_ready), 32'd1);
    fifo_ready = 1'b0;
    #1;
    check("hog_follow_0", 32'(hog_ready), 32'd0);
    fifo_ready = 1'b1;
    #1;
    check("hog_follow_1b", 32'(hog_ready), 32'd1);
    step();

    // start during COLLECT at addr 10 is ignored
    run_load(1'b0, 1'b1, 1'b0, 12'd3780);
    check_timing("glitch");
    step();

    // Random stream gaps, bias 0xFFF
    run_load(1'b1, 1'b0, 1'b0, 12'hFFF);
    check("gap_wr_cnt", 32'(wr_cnt), 32'd36);
    check("gap_bl_cnt", 32'(bl_cnt), 32'd1);
    gaps = 1'b0;
    repeat (5) step();
    check("gap_done_once", 32'(done_rises), 32'd1);
    check("gap_bl_once", 32'(bl_cnt), 32'd1);
    check("gap_bias_held", 32'(bias), 32'hFFF);
    check("gap_done_held", 32'(done), 32'd1);

    // Reset during WRITE of addr 20 aborts the load
    run_load(1'b0, 1'b0, 1'b1, 12'd3780);
    check("abort_seen", 32'(aborted), 32'd1);
    repeat (10) step();
    check("abort_wr_cnt", 32'(wr_cnt), 32'd21);
    check("abort_no_bload", 32'(bl_cnt), 32'd0);
    check("abort_no_done", 32'(done_rises), 32'd0);
    rst = 1'b1;
    repeat (10) step();
    check("post_abort_busy", 32'(busy), 32'd0);
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_wr", 32'(wr_cnt), 32'd21);

    // Fresh load after abort restarts at addr 0
    run_load(1'b0, 1'b0, 1'b0, 12'd3780);
    check_timing("reload");
    step();
    check("reload_bias", 32'(bias), 32'd3780);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
